// File: rtl/memory_bank_responder.sv
// Single-port on-chip memory serving one load and one store channel, serialized
// through a three-state engine with a fixed, parameterizable access latency.
module memory_bank_responder #(
    parameter int unsigned MEMORY_SIZE  = 2**16,
    parameter logic [31:0] BASE_ADDRESS = 32'h0,
    parameter int unsigned LATENCY      = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        i_load_request,
    input  logic [31:0] i_load_address,
    input  logic        i_load_invalidate,
    output logic [31:0] o_load_data,
    output logic        o_load_valid,
    input  logic        i_store_request,
    input  logic [31:0] i_store_address,
    input  logic [31:0] i_store_data,
    input  logic [1:0]  i_store_width,
    output logic        o_store_done
);
    localparam int unsigned DEPTH      = MEMORY_SIZE / 4;
    localparam int unsigned IDX_W      = $clog2(MEMORY_SIZE) - 2;
    localparam logic [31:0] MEM_BYTES  = 32'(MEMORY_SIZE);
    localparam logic [3:0]  CNT_RELOAD = 4'(LATENCY - 1);
    localparam logic [1:0]  WIDTH_BYTE = 2'd0;
    localparam logic [1:0]  WIDTH_HALF = 2'd1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_sel_store;
    logic        r_load_pending;
    logic [31:0] r_load_addr;
    logic        r_store_pending;
    logic [31:0] r_store_addr;
    logic [31:0] r_store_data;
    logic [1:0]  r_store_width;
    logic        r_load_valid;
    logic [31:0] r_load_data;
    logic        r_store_done;
    logic [31:0] r_mem [DEPTH];

    logic             w_load_avail;
    logic             w_abort;
    logic             w_can_start;
    logic             w_start;
    logic             w_access_done;
    logic             w_fire;
    logic             w_fire_store;
    logic             w_store_we;
    logic [31:0]      w_load_offset;
    logic [31:0]      w_store_offset;
    logic             w_load_in_range;
    logic             w_store_in_range;
    logic [IDX_W-1:0] w_load_idx;
    logic [IDX_W-1:0] w_store_idx;
    logic [3:0]       w_store_be;
    logic [31:0]      w_store_lane;

    // An invalidate in the same cycle already hides the load from the engine.
    assign w_load_avail  = r_load_pending && !i_load_invalidate;
    assign w_abort       = (r_state == S_ACCESS) && !r_sel_store && i_load_invalidate;
    assign w_can_start   = (r_state == S_IDLE) || (r_state == S_RESPOND) || w_abort;
    assign w_start       = w_can_start && (r_store_pending || w_load_avail);
    assign w_access_done = (r_state == S_ACCESS) && !w_abort && (r_cnt == 4'd1);
    assign w_fire        = w_access_done || (w_start && (LATENCY == 1));
    assign w_fire_store  = w_access_done ? r_sel_store : r_store_pending;

    assign w_load_offset    = r_load_addr - BASE_ADDRESS;
    assign w_store_offset   = r_store_addr - BASE_ADDRESS;
    assign w_load_in_range  = (w_load_offset < MEM_BYTES);
    assign w_store_in_range = (w_store_offset < MEM_BYTES);
    assign w_load_idx       = w_load_offset[IDX_W+1:2];
    assign w_store_idx      = w_store_offset[IDX_W+1:2];
    assign w_store_we       = w_fire && w_fire_store && w_store_in_range;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_store_be[gi] =
                (r_store_width == WIDTH_BYTE) ? (r_store_addr[1:0] == 2'(gi)) :
                (r_store_width == WIDTH_HALF) ? (r_store_addr[1] == 1'(gi / 2)) : 1'b1;
            assign w_store_lane[gi*8 +: 8] =
                (r_store_width == WIDTH_BYTE) ? r_store_data[7:0] :
                (r_store_width == WIDTH_HALF) ? r_store_data[8*(gi%2) +: 8] :
                                                r_store_data[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (w_store_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_store_be[b]) begin
                    r_mem[w_store_idx][b*8 +: 8] <= w_store_lane[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state         <= S_IDLE;
            r_cnt           <= 4'd0;
            r_sel_store     <= 1'b0;
            r_load_pending  <= 1'b0;
            r_load_addr     <= 32'h0;
            r_store_pending <= 1'b0;
            r_store_addr    <= 32'h0;
            r_store_data    <= 32'h0;
            r_store_width   <= 2'd0;
            r_load_valid    <= 1'b0;
            r_load_data     <= 32'h0;
            r_store_done    <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_store_done <= 1'b0;

            if (i_load_invalidate) begin
                r_load_pending <= 1'b0;
            end else if (i_load_request && !r_load_pending) begin
                r_load_pending <= 1'b1;
                r_load_addr    <= i_load_address;
            end
            if (i_store_request && !r_store_pending) begin
                r_store_pending <= 1'b1;
                r_store_addr    <= i_store_address;
                r_store_data    <= i_store_data;
                r_store_width   <= i_store_width;
            end

            // Pending is released on the response edge so a follow-up request
            // can be captured at the edge that ends the response cycle.
            if (w_fire) begin
                if (w_fire_store) begin
                    r_store_done    <= 1'b1;
                    r_store_pending <= 1'b0;
                end else begin
                    r_load_valid   <= 1'b1;
                    r_load_data    <= w_load_in_range ? r_mem[w_load_idx] : 32'h0;
                    r_load_pending <= 1'b0;
                end
                r_state     <= S_RESPOND;
                r_sel_store <= w_fire_store;
                r_cnt       <= 4'd0;
            end else if (w_start) begin
                r_state     <= S_ACCESS;
                r_sel_store <= r_store_pending;
                r_cnt       <= CNT_RELOAD;
            end else if (w_can_start) begin
                r_state <= S_IDLE;
            end else if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign o_load_valid = r_load_valid;
    assign o_load_data  = r_load_data;
    assign o_store_done = r_store_done;
endmodule

// File: tb/tb_memory_bank_responder.sv
// Scoreboard bench for memory_bank_responder: a byte-array reference model predicts
// each response's edge and data; a negedge monitor pops and compares.
module tb_memory_bank_responder;
    localparam int          LAT  = 3;
    localparam int          MEM  = 1024;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        i_load_request = 1'b0;
    logic [31:0] i_load_address = 32'h0;
    logic        i_load_invalidate = 1'b0;
    logic [31:0] o_load_data;
    logic        o_load_valid;
    logic        i_store_request = 1'b0;
    logic [31:0] i_store_address = 32'h0;
    logic [31:0] i_store_data = 32'h0;
    logic [1:0]  i_store_width = 2'd0;
    logic        o_store_done;

    memory_bank_responder #(
        .MEMORY_SIZE (MEM),
        .BASE_ADDRESS(BASE),
        .LATENCY     (LAT)
    ) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .i_load_request   (i_load_request),
        .i_load_address   (i_load_address),
        .i_load_invalidate(i_load_invalidate),
        .o_load_data      (o_load_data),
        .o_load_valid     (o_load_valid),
        .i_store_request  (i_store_request),
        .i_store_address  (i_store_address),
        .i_store_data     (i_store_data),
        .i_store_width    (i_store_width),
        .o_store_done     (o_store_done)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_store;
        int          at_edge;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mdl_mem [MEM];
    int          cyc = 0;
    int          last_resp = -100;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [31:0] exp_hold = 32'h0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] addr);
        logic [31:0] off;
        int          b;
        off = addr - BASE;
        if (off >= MEM) return 32'h0;
        b = int'(off) & ~3;
        return {mdl_mem[b+3], mdl_mem[b+2], mdl_mem[b+1], mdl_mem[b]};
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] w);
        logic [31:0] off;
        int          b;
        off = addr - BASE;
        if (off < MEM) begin
            if (w == 2'd0) begin
                mdl_mem[int'(off)] = data[7:0];
            end else if (w == 2'd1) begin
                b = int'(off) & ~1;
                mdl_mem[b]   = data[7:0];
                mdl_mem[b+1] = data[15:8];
            end else begin
                b = int'(off) & ~3;
                for (int i = 0; i < 4; i++) mdl_mem[b+i] = data[8*i +: 8];
            end
        end
    endtask

    task automatic next_cycle();
        @(negedge clk_i);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) next_cycle();
    endtask

    // Drives one request cycle; ld_drop marks a load that is expected never to respond.
    task automatic issue(input bit do_ld, input logic [31:0] ld_addr, input bit ld_drop,
                         input bit do_st, input logic [31:0] st_addr, input logic [31:0] st_data,
                         input logic [1:0] st_w, input bit inv);
        int   k;
        exp_t e;
        i_load_request    = do_ld;
        i_load_address    = ld_addr;
        i_load_invalidate = inv;
        i_store_request   = do_st;
        i_store_address   = st_addr;
        i_store_data      = st_data;
        i_store_width     = st_w;
        k = cyc + 1;
        if (do_st) begin
            model_store(st_addr, st_data, st_w);
            e.is_store = 1'b1;
            e.at_edge  = ((k > last_resp) ? k : last_resp) + LAT;
            e.data     = 32'h0;
            sb.push_back(e);
            last_resp = e.at_edge;
        end
        if (do_ld && !ld_drop && !inv) begin
            e.is_store = 1'b0;
            e.at_edge  = ((k > last_resp) ? k : last_resp) + LAT;
            e.data     = model_load(ld_addr);
            sb.push_back(e);
            last_resp = e.at_edge;
        end
        next_cycle();
        i_load_request    = 1'b0;
        i_load_invalidate = 1'b0;
        i_store_request   = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            next_cycle();
            n++;
        end
        check("drain_outstanding", 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    function automatic logic [31:0] rand_addr();
        int r = int'($urandom_range(0, 9));
        if (r == 0) return $urandom;
        if (r == 1) return BASE + MEM + 32'($urandom_range(0, 3));
        if (r == 2) return BASE - 32'($urandom_range(1, 4));
        return BASE + 32'($urandom_range(0, MEM - 1));
    endfunction

    always @(negedge clk_i) begin
        if (mon_en) begin
            if (o_store_done || o_load_valid) begin
                $display("RESP cycle=%0d done=%0b valid=%0b data=%h", cyc, o_store_done, o_load_valid, o_load_data);
                if (o_store_done && o_load_valid) check("both_pulses", 32'h1, 32'h0);
                if (sb.size() == 0) begin
                    check("unexpected_resp", {30'h0, o_store_done, o_load_valid}, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_kind", {31'h0, o_store_done}, {31'h0, e.is_store});
                    check("resp_edge", 32'(cyc), 32'(e.at_edge));
                    if (!e.is_store) begin
                        check("load_data", o_load_data, e.data);
                        exp_hold = e.data;
                    end else if (o_load_valid) begin
                        exp_hold = o_load_data;
                    end
                end
            end
            if (!o_load_valid) check("data_hold", o_load_data, exp_hold);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a1;
        logic [31:0] a2;
        int          op;

        repeat (3) @(negedge clk_i);
        check("reset_valid", {31'h0, o_load_valid}, 32'h0);
        check("reset_done", {31'h0, o_store_done}, 32'h0);
        check("reset_data", o_load_data, 32'h0);
        #2;
        rst_n_i = 1'b1;
        mon_en  = 1'b1;
        idle(2);

        // Fill every word so later loads never observe uninitialized memory.
        for (int w = 0; w < MEM / 4; w++) begin
            issue(0, 32'h0, 0, 1, BASE + 32'(4 * w), $urandom, 2'd2, 0);
            drain(4 * LAT + 8);
        end

        issue(0, 32'h0, 0, 1, BASE + 32'h100, 32'hDEADBEEF, 2'd2, 0);
        drain(4 * LAT + 8);
        issue(1, BASE + 32'h100, 0, 0, 32'h0, 32'h0, 2'd0, 0);
        drain(4 * LAT + 8);

        issue(0, 32'h0, 0, 1, BASE + 32'h200, 32'h0, 2'd2, 0);
        drain(4 * LAT + 8);
        issue(0, 32'h0, 0, 1, BASE + 32'h203, 32'h0000_00AA, 2'd0, 0);
        drain(4 * LAT + 8);
        issue(0, 32'h0, 0, 1, BASE + 32'h201, 32'h0000_1234, 2'd1, 0);
        drain(4 * LAT + 8);
        issue(1, BASE + 32'h200, 0, 0, 32'h0, 32'h0, 2'd0, 0);
        drain(4 * LAT + 8);

        issue(1, BASE + 32'h10, 0, 1, BASE + 32'h10, 32'hCAFE_F00D, 2'd2, 0);
        drain(4 * LAT + 8);

        issue(1, 32'h0000_0040, 0, 0, 32'h0, 32'h0, 2'd0, 0);
        drain(4 * LAT + 8);
        issue(0, 32'h0, 0, 1, 32'h0000_0040, 32'hFFFF_FFFF, 2'd2, 0);
        drain(4 * LAT + 8);
        issue(1, BASE + 32'h40, 0, 0, 32'h0, 32'h0, 2'd0, 0);
        drain(4 * LAT + 8);
        issue(1, BASE + MEM - 32'h4, 0, 0, 32'h0, 32'h0, 2'd0, 0);
        drain(4 * LAT + 8);
        issue(1, BASE + MEM, 0, 0, 32'h0, 32'h0, 2'd0, 0);
        drain(4 * LAT + 8);

        // Load aborted in ACCESS by invalidate, then a normal load.
        issue(1, BASE + 32'h100, 1, 0, 32'h0, 32'h0, 2'd0, 0);
        idle(1);
        i_load_invalidate = 1'b1;
        idle(1);
        i_load_invalidate = 1'b0;
        idle(10);
        issue(1, BASE + 32'h104, 0, 0, 32'h0, 32'h0, 2'd0, 0);
        drain(4 * LAT + 8);

        // Load queued behind a store is invalidated; the store still completes.
        issue(1, BASE + 32'h108, 1, 1, BASE + 32'h108, 32'h1357_9BDF, 2'd2, 0);
        idle(1);
        i_load_invalidate = 1'b1;
        idle(1);
        i_load_invalidate = 1'b0;
        drain(4 * LAT + 8);
        idle(2 * LAT + 4);

        // Load request coinciding with invalidate is discarded.
        issue(1, BASE + 32'h10C, 0, 0, 32'h0, 32'h0, 2'd0, 1);
        idle(2 * LAT + 4);

        // Reset in the middle of a load access.
        issue(1, BASE + 32'h100, 0, 0, 32'h0, 32'h0, 2'd0, 0);
        drain(4 * LAT + 8);
        issue(1, BASE + 32'h200, 1, 0, 32'h0, 32'h0, 2'd0, 0);
        rst_n_i  = 1'b0;
        exp_hold = 32'h0;
        #1;
        check("midreset_valid", {31'h0, o_load_valid}, 32'h0);
        check("midreset_done", {31'h0, o_store_done}, 32'h0);
        check("midreset_data", o_load_data, 32'h0);
        idle(2);
        rst_n_i = 1'b1;
        idle(3 * LAT + 3);
        issue(1, BASE + 32'h200, 0, 0, 32'h0, 32'h0, 2'd0, 0);
        drain(4 * LAT + 8);

        for (int it = 0; it < 150; it++) begin
            op = int'($urandom_range(0, 2));
            a1 = rand_addr();
            a2 = ($urandom_range(0, 3) == 0) ? a1 : rand_addr();
            issue(op != 1, a1, 0, op != 0, a2, $urandom, 2'($urandom_range(0, 2)), 0);
            drain(4 * LAT + 8);
            idle(int'($urandom_range(0, 2)));
        end

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
